// File: rtl/mycpu_pkg.sv
// mycpu_pkg: shared pipeline definitions.
// Holds the EX->MEM data-lane field layout, the exception-lane bit layout,
// the reset PC and a helper that builds the EX->MEM bubble word.
package mycpu_pkg;

  localparam logic [31:0] RESET_PC = 32'hbfc0_0000;

  // EX->MEM data lane: 5 x 32-bit fields.
  // RF write control travels inside the instruction field and is decoded
  // again in MEM; MD and CP0 results share the aux field.
  localparam int unsigned EXM_ALU_LSB   = 0;    // ALU result
  localparam int unsigned EXM_PC_LSB    = 32;   // instruction PC
  localparam int unsigned EXM_INST_LSB  = 64;   // instruction word
  localparam int unsigned EXM_WDATA_LSB = 96;   // store data
  localparam int unsigned EXM_AUX_LSB   = 128;  // MD / CP0 data
  localparam int unsigned EXM_DATA_W    = 160;

  // Exception lane bit positions.
  localparam int unsigned EXC_SYSCALL   = 0;
  localparam int unsigned EXC_BREAK     = 1;
  localparam int unsigned EXC_RESERVED  = 2;
  localparam int unsigned EXC_OVERFLOW  = 3;
  localparam int unsigned EXC_ADES      = 4;
  localparam int unsigned EXC_ADEL      = 5;
  localparam int unsigned EXC_ADEF      = 6;
  localparam int unsigned EXC_SLOT      = 7;
  localparam int unsigned EXC_BADV_LSB  = 8;   // bad_vaddr[31:0]
  localparam int unsigned EXC_EPC_LSB   = 40;  // faulting PC[31:0]
  localparam int unsigned EXM_EXC_W     = 72;

  // Same layout as the bit positions above, for consumers that prefer fields.
  typedef struct packed {
    logic [31:0] epc;
    logic [31:0] bad_vaddr;
    logic        slot;
    logic        adef;
    logic        adel;
    logic        ades;
    logic        overflow;
    logic        reserved;
    logic        brk;
    logic        syscall;
  } exm_exc_t;

  // Bubble for the EX->MEM stage: all-zero except PC = RESET_PC, so an empty
  // MEM stage never reports a bogus PC to CP0.
  function automatic logic [EXM_DATA_W-1:0] exm_bubble();
    logic [EXM_DATA_W-1:0] r;
    r = '0;
    r[EXM_PC_LSB +: 32] = RESET_PC;
    return r;
  endfunction

endpackage

// File: rtl/pipe_buf_ram.sv
// pipe_buf_ram: DEPTH x WIDTH register array, one synchronous write port and
// one asynchronous read port. Contents are not reset; validity is tracked by
// the owner.
// Ports:
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  read data (combinational from raddr)
module pipe_buf_ram import mycpu_pkg::*; #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = EXM_DATA_W + EXM_EXC_W
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: elastic valid/ready buffer between two pipeline stages,
// carrying a data lane and an exception lane.
// Ports:
//   clk, resetn           clock, synchronous active-low reset
//   in_valid/in_ready     upstream handshake; in_ready is registered-state
//                         based (plus flush) and never looks at out_ready
//   in_data, in_exc       upstream lanes; nonzero in_exc marks an exception
//   out_valid/out_ready   downstream handshake on the head entry
//   out_data, out_exc     head entry, or BUBBLE_DATA / 0 when empty
//   flush                 drop everything; push/pop in that cycle ignored
//   count                 occupancy
//   exc_pending           some buffered entry carries an exception
module pipe_stage_buf import mycpu_pkg::*; #(
  parameter int unsigned        DATA_W      = EXM_DATA_W,
  parameter int unsigned        EXC_W       = EXM_EXC_W,
  parameter int unsigned        DEPTH       = 2,
  parameter logic [DATA_W-1:0]  BUBBLE_DATA = {DATA_W{1'b0}},
  parameter bit                 KILL_ON_EXC = 1'b1
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  input  logic [EXC_W-1:0]           in_exc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [EXC_W-1:0]           out_exc,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       exc_pending
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned ENT_W = DATA_W + EXC_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] blk_ptr_q, blk_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             blocked_q, blocked_d;
  logic             exc_pending_q, exc_pending_d;
  logic [DEPTH-1:0] exc_vec_q, exc_vec_d;

  logic             push;
  logic             pop;
  logic             in_exc_nz;
  logic             ram_we;
  logic [ENT_W-1:0] rd_entry;

  assign in_exc_nz = |in_exc;

  assign in_ready  = (count_q != FULL_CNT) & ~blocked_q & ~flush;
  assign out_valid = (count_q != '0);

  // in_ready already excludes flush, so only pop needs explicit masking.
  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready & ~flush;

  assign ram_we = push & resetn;

  pipe_buf_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr_q),
    .wdata ({in_exc, in_data}),
    .raddr (rd_ptr_q),
    .rdata (rd_entry)
  );

  assign out_data    = out_valid ? rd_entry[DATA_W-1:0]     : BUBBLE_DATA;
  assign out_exc     = out_valid ? rd_entry[ENT_W-1:DATA_W] : '0;
  assign count       = count_q;
  assign exc_pending = exc_pending_q;

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    blk_ptr_d     = blk_ptr_q;
    count_d       = count_q;
    blocked_d     = blocked_q;
    exc_vec_d     = exc_vec_q;
    exc_pending_d = exc_pending_q;

    if (flush) begin
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      count_d       = '0;
      blocked_d     = 1'b0;
      exc_vec_d     = '0;
      exc_pending_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase

      // Pop slot and push slot can only coincide when the buffer is empty
      // (no pop) or full (no push), so clear-then-set never collides.
      if (pop) begin
        exc_vec_d[rd_ptr_q] = 1'b0;
      end
      if (push) begin
        exc_vec_d[wr_ptr_q] = in_exc_nz;
      end
      exc_pending_d = |exc_vec_d;

      if (KILL_ON_EXC) begin
        if (pop && blocked_q && (rd_ptr_q == blk_ptr_q)) begin
          blocked_d = 1'b0;
        end
        if (push && in_exc_nz) begin
          blocked_d = 1'b1;
          blk_ptr_d = wr_ptr_q;
        end
      end else begin
        blocked_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      blk_ptr_q     <= '0;
      count_q       <= '0;
      blocked_q     <= 1'b0;
      exc_vec_q     <= '0;
      exc_pending_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      blk_ptr_q     <= blk_ptr_d;
      count_q       <= count_d;
      blocked_q     <= blocked_d;
      exc_vec_q     <= exc_vec_d;
      exc_pending_q <= exc_pending_d;
    end
  end

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised elastic pipeline-stage buffer. It replaces the fixed stall-gated inter-stage registers (EX→MEM and peers) with a valid/ready FIFO of configurable depth carrying a data lane and an exception lane. It sits between two pipeline stages and provides bubble insertion, a pipeline flush, and optional blocking of younger instructions behind an excepting one.

## Interface
Parameters:
- DATA_W, 160: data-lane width (ALU result, MD data, PC, instruction, store data, RF control, CP0 data).
- EXC_W, 72: exception-lane width (exception flags, delay-slot bit, bad address).
- DEPTH, 2: entry count; power of two, ≥2.
- BUBBLE_DATA, {DATA_W{1'b0}}: value driven on out_data when empty.
- KILL_ON_EXC, 1: 1 = stop accepting input while an entry with nonzero exc is buffered.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  synchronous reset, active low.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  buffer accepts an entry this cycle.
- in_data  in  DATA_W  upstream data lane.
- in_exc  in  EXC_W  upstream exception lane; nonzero means excepting.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream consumes the head.
- out_data  out  DATA_W  head data lane, or BUBBLE_DATA when empty.
- out_exc  out  EXC_W  head exception lane, or 0 when empty.
- flush  in  1  discard all contents (exception/ERET redirect).
- count  out  $clog2(DEPTH+1)  occupancy.
- exc_pending  out  1  some buffered entry has nonzero exc.

## Operation
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- Storage: DEPTH-entry array {exc, data}. wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap naturally modulo DEPTH. count is a separate register.
- count' = count + push − pop. Push and pop in the same cycle leave count unchanged and advance both pointers.
- in_ready = (count != DEPTH) & ~blocked & ~flush. It is derived from registered state plus flush only and never depends combinationally on out_ready.
- out_valid = (count != 0). out_data and out_exc read the head at rd_ptr. When empty they show BUBBLE_DATA and 0.
- blocked (KILL_ON_EXC=1 only):
  - Set on push with in_exc != 0.
  - Cleared on pop of the entry at the position recorded at set time, or on flush.
  - For KILL_ON_EXC=0 it is tied to 0.
- exc_pending is a registered flag:
  - Set on a push with nonzero exc.
  - Cleared when the last excepting entry pops (tracked by a per-entry exc bit vector OR-reduced), or on flush.
- Priority: reset > flush > push/pop.
  - Flush: count, wr_ptr, rd_ptr, blocked and exc_pending all clear next cycle.
  - A push or pop in the flush cycle is ignored. Downstream receives the same flush.
- Full: in_ready=0, so no push. Pop-only then frees one slot, and in_ready rises the next cycle.
- Empty: a pop cannot occur. A push makes out_valid high the next cycle.

## Timing
- Reset values:
  - in_ready=1, out_valid=0, out_data=BUBBLE_DATA, out_exc=0.
  - count=0, exc_pending=0, blocked=0, pointers=0.
- Latency: an entry pushed in cycle N is visible on out_* in cycle N+1. There is no combinational in→out path.
- Throughput: 1 entry/cycle sustained while out_ready=1 and nothing is blocked.
- in_ready reacts to a pop one cycle later (registered-ready skid behaviour). DEPTH≥2 guarantees full throughput.
- Reset asserted mid-transfer: all contents are lost next edge, and outputs take their reset values.

## Structure
- Shared package mycpu_pkg holds:
  - EX→MEM data-lane field offsets and EXM_DATA_W.
  - Exception-lane bit positions: syscall, break, reserved, overflow, AdES, AdEL, AdEF, slot, bad_vaddr[31:0].
  - EXM_EXC_W and RESET_PC=32'hbfc00000.
- The EX→MEM instance sets BUBBLE_DATA with the PC field = RESET_PC.
- One sub-module: pipe_buf_ram, the DEPTH×(DATA_W+EXC_W) register array with one write port and one async read port. Pointer and count control stays in the top module.

## Test plan
- Reset: hold resetn=0 for 2 cycles with in_valid=1 → count=0, out_valid=0, in_ready=1, out_data=BUBBLE_DATA.
- Fill/drain, DEPTH=2: push D1, D2 with out_ready=0 → count=2, in_ready=0. Then set out_ready=1 → D1 then D2 appear in order, and in_ready returns 1 cycle after the first pop.
- Streaming: in_valid=out_ready=1 for 10 cycles with data 1..10 → outputs 1..10 one cycle delayed, count never exceeds 1.
- Wrap-around: 7 pushes with interleaved pops at DEPTH=4 → FIFO order preserved across pointer wrap.
- Flush: count=2 and a simultaneous push, then assert flush → next cycle count=0, out_valid=0, and the pushed entry is absent.
- Exception block, KILL_ON_EXC=1: push an entry with exc=AdEL, then offer D3 → in_ready=0 and exc_pending=1 until the AdEL entry pops. D3 is accepted the following cycle. With KILL_ON_EXC=0, D3 is accepted immediately.
